// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - oversampling UART receiver with configurable framing
module uart_rx_param #(
  parameter int CLK_HZ     = 12_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 brk,
  output logic                 busy
);
  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);

  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [TW-1:0] T_S0      = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1      = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_S2      = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST    = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DBITS     = 4'(DATA_BITS);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;

  logic [2:0]           state;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [DW-1:0]        div_cnt;
  logic [TW-1:0]        tick_cnt;
  logic                 samp0, samp1;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] data_sr;
  logic                 par_bit, stop_cnt, stop0, ferr;

  logic tick, commit, bit_end, voted, fall, done;
  logic first_stop, par_sum, is_brk, frame_err_w, parity_err_w;

  // Synchronizer and edge history preset high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_comb begin
    tick         = (state != S_IDLE) && (div_cnt == DIV_LAST);
    commit       = tick && (tick_cnt == T_S2);
    bit_end      = tick && (tick_cnt == T_LAST);
    voted        = (samp0 & samp1) | (samp0 & rx_sync) | (samp1 & rx_sync);
    fall         = rx_prev & ~rx_sync;
    done         = commit && (state == S_STOP) && (stop_cnt == STOP_LAST);
    first_stop   = STOP_LAST ? stop0 : voted;
    par_sum      = (^data_sr) ^ par_bit;
    is_brk       = (data_sr == '0) && ((PARITY == 0) || !par_bit) && !first_stop;
    frame_err_w  = ferr | ~voted;
    parity_err_w = 1'b0;
    if (PARITY == 1)
      parity_err_w = ~par_sum;
    else if (PARITY == 2)
      parity_err_w = par_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      tick_cnt <= '0;
      samp0    <= 1'b1;
      samp1    <= 1'b1;
      bit_cnt  <= '0;
      data_sr  <= '0;
      par_bit  <= 1'b0;
      stop_cnt <= 1'b0;
      stop0    <= 1'b1;
      ferr     <= 1'b0;
    end else begin
      // In WAIT_IDLE the counters measure a continuous high period, so any low restarts them.
      if (state == S_IDLE || (state == S_WAIT && !rx_sync)) begin
        div_cnt  <= '0;
        tick_cnt <= '0;
      end else if (tick) begin
        div_cnt  <= '0;
        tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (tick && tick_cnt == T_S0) samp0 <= rx_sync;
      if (tick && tick_cnt == T_S1) samp1 <= rx_sync;

      case (state)
        S_IDLE: begin
          if (fall) begin
            state    <= S_START;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            ferr     <= 1'b0;
          end
        end
        S_START: begin
          if (commit && voted)
            state <= S_IDLE;
          else if (bit_end)
            state <= S_DATA;
        end
        S_DATA: begin
          if (commit) begin
            data_sr <= {voted, data_sr[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          if (bit_end && bit_cnt == DBITS)
            state <= (PARITY != 0) ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          if (commit) par_bit <= voted;
          if (bit_end) state <= S_STOP;
        end
        S_STOP: begin
          if (commit) begin
            if (stop_cnt == STOP_LAST) begin
              if (is_brk || !voted) begin
                state    <= S_WAIT;
                div_cnt  <= '0;
                tick_cnt <= '0;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              stop0 <= voted;
              ferr  <= ~voted;
            end
          end else if (bit_end) begin
            stop_cnt <= 1'b1;
          end
        end
        S_WAIT: begin
          if (bit_end) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Delivery: a completed word either loads the output register or is counted as an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      brk        <= 1'b0;
    end else begin
      overrun <= 1'b0;
      brk     <= 1'b0;
      if (rx_valid && rx_ready)
        rx_valid <= 1'b0;
      if (done) begin
        if (is_brk) begin
          brk <= 1'b1;
        end else if (!rx_valid || rx_ready) begin
          rx_data    <= data_sr;
          frame_err  <= frame_err_w;
          parity_err <= parity_err_w;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - randomized self-checking bench for uart_rx_param
`timescale 1ns/1ps
module tb_uart_rx_param;
  localparam int FCLK = 4_800_000;
  localparam int FBAUD = 100_000;
  localparam int FDIV = FCLK / (FBAUD * 16);
  localparam int FBIT = FDIV * 16;
  localparam int DBIT = 1248;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_f = 1'b1, rx_p = 1'b1, rx_d = 1'b1;
  logic ready_f = 1'b1, ready_p = 1'b1, ready_d = 1'b1;
  logic [7:0] data_f, data_p, data_d;
  logic valid_f, ferr_f, perr_f, ov_o_f, brk_o_f, busy_f;
  logic valid_p, ferr_p, perr_p, ov_o_p, brk_o_p, busy_p;
  logic valid_d, ferr_d, perr_d, ov_o_d, brk_o_d, busy_d;

  always #5 clk = ~clk;

  uart_rx_param #(.CLK_HZ(FCLK), .BAUD(FBAUD)) dut_f (
    .clk(clk), .rst_n(rst_n), .rx(rx_f), .rx_data(data_f), .rx_valid(valid_f),
    .rx_ready(ready_f), .frame_err(ferr_f), .parity_err(perr_f), .overrun(ov_o_f),
    .brk(brk_o_f), .busy(busy_f));

  uart_rx_param #(.CLK_HZ(FCLK), .BAUD(FBAUD), .PARITY(2), .STOP_BITS(2)) dut_p (
    .clk(clk), .rst_n(rst_n), .rx(rx_p), .rx_data(data_p), .rx_valid(valid_p),
    .rx_ready(ready_p), .frame_err(ferr_p), .parity_err(perr_p), .overrun(ov_o_p),
    .brk(brk_o_p), .busy(busy_p));

  uart_rx_param dut_d (
    .clk(clk), .rst_n(rst_n), .rx(rx_d), .rx_data(data_d), .rx_valid(valid_d),
    .rx_ready(ready_d), .frame_err(ferr_d), .parity_err(perr_d), .overrun(ov_o_d),
    .brk(brk_o_d), .busy(busy_d));

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  logic [9:0] got_f[$], got_p[$], got_d[$];
  int ov_f = 0, brk_f = 0, ov_p = 0, brk_p = 0, busy_cnt_f = 0, rise_f = -1;
  logic vprev_f = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Accepted words and pulse counts, sampled 1 ns after the falling edge.
  always @(negedge clk) begin
    #1;
    if (valid_f && ready_f) got_f.push_back({ferr_f, perr_f, data_f});
    if (valid_p && ready_p) got_p.push_back({ferr_p, perr_p, data_p});
    if (valid_d && ready_d) got_d.push_back({ferr_d, perr_d, data_d});
    if (ov_o_f) ov_f++;
    if (brk_o_f) brk_f++;
    if (ov_o_p || ov_o_d) ov_p++;
    if (brk_o_p || brk_o_d) brk_p++;
    if (busy_f) busy_cnt_f++;
    if (valid_f && !vprev_f) rise_f = cyc;
    vprev_f = valid_f;
  end

  task automatic set_rx(input int ch, input logic v);
    case (ch)
      0: rx_f = v;
      1: rx_p = v;
      default: rx_d = v;
    endcase
  endtask

  task automatic send_bits(input int ch, input logic [15:0] bits, input int n, input int bclk);
    for (int i = 0; i < n; i++) begin
      set_rx(ch, bits[i]);
      repeat (bclk) @(negedge clk);
    end
    set_rx(ch, 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #2;
    n_chk++;
    if ({data_f, valid_f, ferr_f, perr_f, ov_o_f, brk_o_f, busy_f} !== 14'h0)
      $display("FAIL reset_outputs_f: got %h expected 0", {data_f, valid_f, ferr_f, perr_f, ov_o_f, brk_o_f, busy_f});
    else n_pass++;
    n_chk++;
    if ({valid_p, busy_p, valid_d, busy_d} !== 4'h0)
      $display("FAIL reset_outputs_pd: got %b expected 0000", {valid_p, busy_p, valid_d, busy_d});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_chk++;
    if (busy_f !== 1'b0) $display("FAIL idle_after_reset: busy %b expected 0", busy_f);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] exp_q[$];
    logic [7:0] d;
    logic [9:0] g;
    int c0, lat, lo, hi, n;
    lo = 9 * FBIT + 7 * FDIV;
    hi = 9 * FBIT + 10 * FDIV + 5;
    ready_f = 1'b1;
    for (int i = 0; i < 15; i++) begin
      d = (i < 6) ? 8'(i + 1) : (i == 6) ? 8'h68 : 8'($urandom);
      exp_q.push_back(d);
      rise_f = -1;
      c0 = cyc;
      send_bits(0, {6'b0, 1'b1, d, 1'b0}, 10, FBIT);
      lat = rise_f - c0;
      n_chk++;
      if (rise_f < 0 || lat < lo || lat > hi)
        $display("FAIL basic_latency%0d: got %0d expected %0d..%0d", i, lat, lo, hi);
      else n_pass++;
      repeat ($urandom_range(0, 2 * FBIT)) @(negedge clk);
    end
    repeat (FBIT) @(negedge clk);
    n = got_f.size();
    n_chk++;
    if (n !== 15) $display("FAIL basic_count: got %0d expected 15", n);
    else n_pass++;
    for (int i = 0; i < 15 && got_f.size() > 0; i++) begin
      g = got_f.pop_front();
      n_chk++;
      if (g !== {2'b00, exp_q[i]}) $display("FAIL basic_word%0d: got %h expected %h", i, g, {2'b00, exp_q[i]});
      else n_pass++;
    end
  endtask

  task automatic test_false_start();
    int w0, b0, o0, k0, bc;
    w0 = got_f.size(); b0 = busy_cnt_f; o0 = ov_f; k0 = brk_f;
    rx_f = 1'b0;
    repeat (4) @(negedge clk);
    rx_f = 1'b1;
    repeat (3 * FBIT) @(negedge clk);
    bc = busy_cnt_f - b0;
    n_chk++;
    if (bc <= 0 || bc >= FBIT) $display("FAIL glitch_busy: got %0d cycles expected 1..%0d", bc, FBIT - 1);
    else n_pass++;
    n_chk++;
    if (got_f.size() != w0 || ov_f != o0 || brk_f != k0)
      $display("FAIL glitch_quiet: got words %0d ov %0d brk %0d expected %0d %0d %0d", got_f.size(), ov_f, brk_f, w0, o0, k0);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int w0, o0;
    logic [9:0] g;
    w0 = got_f.size(); o0 = ov_f;
    ready_f = 1'b0;
    send_bits(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10, FBIT);
    repeat (FBIT) @(negedge clk);
    send_bits(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10, FBIT);
    repeat (FBIT) @(negedge clk);
    n_chk++;
    if (valid_f !== 1'b1 || data_f !== 8'h11) $display("FAIL overrun_hold: got v%b %h expected v1 11", valid_f, data_f);
    else n_pass++;
    n_chk++;
    if (ov_f - o0 != 1) $display("FAIL overrun_pulses: got %0d expected 1", ov_f - o0);
    else n_pass++;
    ready_f = 1'b1;
    @(negedge clk);
    #2;
    n_chk++;
    if (valid_f !== 1'b0) $display("FAIL overrun_release: valid %b expected 0", valid_f);
    else n_pass++;
    n_chk++;
    if (got_f.size() != w0 + 1) $display("FAIL overrun_count: got %0d expected %0d", got_f.size(), w0 + 1);
    else begin
      g = got_f.pop_front();
      if (g !== 10'h011) $display("FAIL overrun_word: got %h expected 011", g);
      else n_pass++;
    end
  endtask

  task automatic test_frame_err();
    logic [9:0] g;
    send_bits(0, {5'b0, 1'b0, 1'b0, 8'h55, 1'b0}, 11, FBIT);
    rx_f = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy_f !== 1'b1) $display("FAIL ferr_wait_low: busy %b expected 1", busy_f);
    else n_pass++;
    rx_f = 1'b1;
    repeat (FBIT / 2) @(negedge clk);
    n_chk++;
    if (busy_f !== 1'b1) $display("FAIL ferr_wait_mid: busy %b expected 1", busy_f);
    else n_pass++;
    repeat (FBIT / 2 + 8) @(negedge clk);
    n_chk++;
    if (busy_f !== 1'b0) $display("FAIL ferr_wait_end: busy %b expected 0", busy_f);
    else n_pass++;
    send_bits(0, {6'b0, 1'b1, 8'h33, 1'b0}, 10, FBIT);
    repeat (FBIT) @(negedge clk);
    n_chk++;
    if (got_f.size() != 2) $display("FAIL ferr_count: got %0d expected 2", got_f.size());
    else begin
      g = got_f.pop_front();
      if (g !== {2'b10, 8'h55}) $display("FAIL ferr_word: got %h expected %h", g, {2'b10, 8'h55});
      else begin
        g = got_f.pop_front();
        if (g !== {2'b00, 8'h33}) $display("FAIL ferr_next: got %h expected %h", g, {2'b00, 8'h33});
        else n_pass++;
      end
    end
  endtask

  task automatic test_break();
    int w0, k0;
    w0 = got_f.size(); k0 = brk_f;
    rx_f = 1'b0;
    repeat (15 * FBIT) @(negedge clk);
    n_chk++;
    if (busy_f !== 1'b1) $display("FAIL brk_busy_low: busy %b expected 1", busy_f);
    else n_pass++;
    rx_f = 1'b1;
    repeat (FBIT / 2) @(negedge clk);
    n_chk++;
    if (busy_f !== 1'b1) $display("FAIL brk_busy_mid: busy %b expected 1", busy_f);
    else n_pass++;
    repeat (FBIT / 2 + 8) @(negedge clk);
    n_chk++;
    if (busy_f !== 1'b0) $display("FAIL brk_busy_end: busy %b expected 0", busy_f);
    else n_pass++;
    n_chk++;
    if (brk_f - k0 != 1 || got_f.size() != w0)
      $display("FAIL brk_pulse: got brk %0d words %0d expected 1 %0d", brk_f - k0, got_f.size(), w0);
    else n_pass++;
  endtask

  task automatic test_parity();
    logic [7:0] pd[9];
    logic pp[9];
    logic [1:0] ps[9];
    logic [9:0] e, g;
    pd[0] = 8'hA5; pp[0] = 1'b0; ps[0] = 2'b11;
    pd[1] = 8'hA5; pp[1] = 1'b1; ps[1] = 2'b11;
    pd[2] = 8'hC3; pp[2] = 1'b0; ps[2] = 2'b10;
    for (int i = 3; i < 9; i++) begin
      pd[i] = 8'($urandom); pp[i] = 1'($urandom); ps[i] = 2'b11;
    end
    for (int i = 0; i < 9; i++) begin
      send_bits(1, {4'b0, ps[i][1], ps[i][0], pp[i], pd[i], 1'b0}, 12, FBIT);
      repeat (2 * FBIT) @(negedge clk);
    end
    for (int i = 0; i < 9; i++) begin
      e = {~(ps[i][0] & ps[i][1]), 1'(($countones(pd[i]) + pp[i]) % 2 != 0), pd[i]};
      n_chk++;
      if (got_p.size() == 0) $display("FAIL parity_word%0d: got none expected %h", i, e);
      else begin
        g = got_p.pop_front();
        if (g !== e) $display("FAIL parity_word%0d: got %h expected %h", i, g, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic [9:0] g;
    ready_f = 1'b0;
    send_bits(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10, FBIT);
    send_bits(0, 16'h0006, 4, FBIT);
    rx_f = 1'b0;
    repeat (FBIT / 2) @(negedge clk);
    n_chk++;
    if (valid_f !== 1'b1 || data_f !== 8'h5A || busy_f !== 1'b1)
      $display("FAIL rstmid_before: got v%b %h busy%b expected v1 5a busy1", valid_f, data_f, busy_f);
    else n_pass++;
    rst_n = 1'b0;
    rx_f = 1'b1;
    #2;
    n_chk++;
    if ({data_f, valid_f, ferr_f, perr_f, ov_o_f, brk_o_f, busy_f} !== 14'h0)
      $display("FAIL rstmid_outputs: got %h expected 0", {data_f, valid_f, ferr_f, perr_f, ov_o_f, brk_o_f, busy_f});
    else n_pass++;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    ready_f = 1'b1;
    repeat (FBIT) @(negedge clk);
    d = 8'($urandom);
    send_bits(0, {6'b0, 1'b1, d, 1'b0}, 10, FBIT);
    repeat (FBIT) @(negedge clk);
    n_chk++;
    if (got_f.size() != 1) $display("FAIL rstmid_count: got %0d expected 1", got_f.size());
    else begin
      g = got_f.pop_front();
      if (g !== {2'b00, d}) $display("FAIL rstmid_word: got %h expected %h", g, {2'b00, d});
      else n_pass++;
    end
  endtask

  task automatic test_default_rate();
    logic [7:0] dd[2];
    logic [9:0] g;
    dd[0] = 8'h68;
    dd[1] = 8'($urandom);
    for (int i = 0; i < 2; i++) begin
      send_bits(2, {6'b0, 1'b1, dd[i], 1'b0}, 10, DBIT);
      repeat (DBIT / 2) @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (got_d.size() == 0) $display("FAIL default_word%0d: got none expected %h", i, dd[i]);
      else begin
        g = got_d.pop_front();
        if (g !== {2'b00, dd[i]}) $display("FAIL default_word%0d: got %h expected %h", i, g, {2'b00, dd[i]});
        else n_pass++;
      end
    end
    n_chk++;
    if (ov_p != 0 || brk_p != 0 || got_p.size() != 0 || got_d.size() != 0)
      $display("FAIL others_quiet: got ov %0d brk %0d extra %0d expected 0 0 0", ov_p, brk_p, got_p.size() + got_d.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_overrun();
    test_frame_err();
    test_break();
    test_parity();
    test_reset_mid();
    test_default_rate();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
